// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle teaching processor: opcodes, FSM states,
// bus-source selects and IR field positions.
package proc_pkg;

  localparam int IR_W   = 9;
  localparam int III_HI = 8;
  localparam int III_LO = 6;
  localparam int XXX_HI = 5;
  localparam int XXX_LO = 3;
  localparam int YYY_HI = 2;
  localparam int YYY_LO = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } proc_state_t;

  typedef enum logic [2:0] {
    BUS_ZERO = 3'd0,
    BUS_RX   = 3'd1,
    BUS_RY   = 3'd2,
    BUS_DIN  = 3'd3,
    BUS_G    = 3'd4
  } bus_sel_t;

endpackage

// File: rtl/addSub.sv
// Existing 16-bit adder/subtractor: data_out = rx + ry (add_sub=0) or rx - ry (add_sub=1),
// modulo 2^16 with no flags.
module addSub (
  input  logic        add_sub,
  input  logic [15:0] rx,
  input  logic [15:0] ry,
  output logic [15:0] data_out
);

  assign data_out = add_sub ? (rx - ry) : (rx + ry);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Next-state and control decode for the T0-T3 instruction sequencer.
// Opcode 100 acts as mvnz only when PROC_MVNZ_EN is defined; otherwise it is a NOP.
import proc_pkg::*;

module proc_ctrl_fsm (
  input  proc_state_t      i_state,
  input  logic [IR_W-1:0]  i_ir,
  input  logic             i_run,
  input  logic             i_g_nz,
  output proc_state_t      o_next_state,
  output bus_sel_t         o_bus_sel,
  output logic             o_ir_wr,
  output logic             o_rx_wr,
  output logic             o_a_wr,
  output logic             o_g_wr,
  output logic             o_add_sub,
  output logic             o_done
);

  logic [2:0] w_op;
  logic [5:0] w_unused_fields;

  assign w_op            = i_ir[III_HI:III_LO];
  assign w_unused_fields = i_ir[XXX_HI:YYY_LO];

`ifndef PROC_MVNZ_EN
  logic w_unused_g_nz;
  assign w_unused_g_nz = i_g_nz;
`endif

  always_comb begin
    o_next_state = T0;
    o_bus_sel    = BUS_ZERO;
    o_ir_wr      = 1'b0;
    o_rx_wr      = 1'b0;
    o_a_wr       = 1'b0;
    o_g_wr       = 1'b0;
    o_add_sub    = 1'b0;
    o_done       = 1'b0;
    case (i_state)
      T0: begin
        if (i_run) begin
          o_ir_wr      = 1'b1;
          o_next_state = T1;
        end else begin
          o_next_state = T0;
        end
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            o_bus_sel = BUS_RY;
            o_rx_wr   = 1'b1;
            o_done    = 1'b1;
          end
          OP_MVI: begin
            o_bus_sel = BUS_DIN;
            o_rx_wr   = 1'b1;
            o_done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            o_bus_sel    = BUS_RX;
            o_a_wr       = 1'b1;
            o_next_state = T2;
          end
`ifdef PROC_MVNZ_EN
          OP_MVNZ: begin
            o_bus_sel = BUS_RY;
            o_rx_wr   = i_g_nz;
            o_done    = 1'b1;
          end
`endif
          default: begin
            o_done = 1'b1;
          end
        endcase
      end
      T2: begin
        o_bus_sel    = BUS_RY;
        o_g_wr       = 1'b1;
        o_add_sub    = (w_op == OP_SUB);
        o_next_state = T3;
      end
      T3: begin
        o_bus_sel = BUS_G;
        o_rx_wr   = 1'b1;
        o_done    = 1'b1;
      end
      default: begin
        o_next_state = T0;
      end
    endcase
  end

endmodule

// File: rtl/proc_ctrl_datapath.sv
// Top of the 16-bit teaching processor: register file, A, G, IR, shared bus and addSub.
// Optional mvnz instruction is enabled by defining PROC_MVNZ_EN.
import proc_pkg::*;

module proc_ctrl_datapath #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              done,
  output logic [DATA_W-1:0] bus
);

  logic [DATA_W-1:0] r_regs [0:7];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [IR_W-1:0]   r_ir;
  proc_state_t       r_state;

  proc_state_t       w_next_state;
  bus_sel_t          w_bus_sel;
  logic              w_ir_wr;
  logic              w_rx_wr;
  logic              w_a_wr;
  logic              w_g_wr;
  logic              w_add_sub;
  logic              w_done;
  logic [2:0]        w_rx_idx;
  logic [2:0]        w_ry_idx;
  logic [DATA_W-1:0] w_sum;

  assign w_rx_idx = r_ir[XXX_HI:XXX_LO];
  assign w_ry_idx = r_ir[YYY_HI:YYY_LO];

  proc_ctrl_fsm u_fsm (
    .i_state      (r_state),
    .i_ir         (r_ir),
    .i_run        (run),
    .i_g_nz       (r_g != '0),
    .o_next_state (w_next_state),
    .o_bus_sel    (w_bus_sel),
    .o_ir_wr      (w_ir_wr),
    .o_rx_wr      (w_rx_wr),
    .o_a_wr       (w_a_wr),
    .o_g_wr       (w_g_wr),
    .o_add_sub    (w_add_sub),
    .o_done       (w_done)
  );

  // Shared bus source mux
  always_comb begin
    bus = '0;
    case (w_bus_sel)
      BUS_ZERO: bus = '0;
      BUS_RX:   bus = r_regs[w_rx_idx];
      BUS_RY:   bus = r_regs[w_ry_idx];
      BUS_DIN:  bus = din;
      BUS_G:    bus = r_g;
      default:  bus = '0;
    endcase
  end

  addSub u_addsub (
    .add_sub  (w_add_sub),
    .rx       (r_a),
    .ry       (bus),
    .data_out (w_sum)
  );

  // Reset overrides any pending write so an aborted instruction leaves no trace.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if (w_ir_wr) r_ir <= din[IR_W-1:0];
      if (w_rx_wr) r_regs[w_rx_idx] <= bus;
      if (w_a_wr)  r_a <= bus;
      if (w_g_wr)  r_g <= w_sum;
    end
  end

  assign done = w_done & ~reset;

endmodule

// File: tb/tb_proc_ctrl_datapath.sv
// Self-checking bench for proc_ctrl_datapath: table of instructions with expected
// latency and done-cycle bus value, plus reset, idle, abort and back-to-back sequences.
module tb_proc_ctrl_datapath;

`ifdef PROC_MVNZ_EN
  localparam bit MVNZ = 1'b1;
`else
  localparam bit MVNZ = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        done;
  logic [15:0] bus;

  int n_pass;
  int n_total;

  proc_ctrl_datapath #(.DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .din   (din),
    .done  (done),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]  ir;
    logic [15:0] imm;
    int          lat;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t vecs [27];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%h, expected 0x%h", name, idx, act, exp);
  endtask

  task automatic exec(input vec_t v, input int idx);
    int          lat;
    bit          seen;
    logic [15:0] b;
    lat  = 0;
    seen = 1'b0;
    b    = 16'hxxxx;
    @(negedge clock);
    din = {7'd0, v.ir};
    run = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clock);
      run = 1'b0;
      din = v.imm;
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
        b    = bus;
      end
    end
    chk("latency", idx, 16'(lat), 16'(v.lat));
    chk("done_bus", idx, b, v.exp_bus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tmp;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{9'h040, 16'h0005, 1, 16'h0005};  // mvi R0,5
    vecs[1]  = '{9'h048, 16'h0003, 1, 16'h0003};  // mvi R1,3
    vecs[2]  = '{9'h081, 16'h0000, 3, 16'h0008};  // add R0,R1
    vecs[3]  = '{9'h000, 16'h0000, 1, 16'h0008};  // mv R0,R0 (read back)
    vecs[4]  = '{9'h040, 16'h0005, 1, 16'h0005};  // mvi R0,5
    vecs[5]  = '{9'h0C1, 16'h0000, 3, 16'h0002};  // sub R0,R1
    vecs[6]  = '{9'h050, 16'h0000, 1, 16'h0000};  // mvi R2,0
    vecs[7]  = '{9'h058, 16'h0001, 1, 16'h0001};  // mvi R3,1
    vecs[8]  = '{9'h0D3, 16'h0000, 3, 16'hFFFF};  // sub R2,R3 wraps
    vecs[9]  = '{9'h068, 16'hFFFF, 1, 16'hFFFF};  // mvi R5,FFFF
    vecs[10] = '{9'h070, 16'h0001, 1, 16'h0001};  // mvi R6,1
    vecs[11] = '{9'h0AE, 16'h0000, 3, 16'h0000};  // add R5,R6 wraps
    vecs[12] = '{9'h040, 16'h1234, 1, 16'h1234};  // mvi R0,1234
    vecs[13] = '{9'h020, 16'h0000, 1, 16'h1234};  // mv R4,R0
    vecs[14] = '{9'h024, 16'h0000, 1, 16'h1234};  // mv R4,R4
    vecs[15] = '{9'h050, 16'h0007, 1, 16'h0007};  // mvi R2,7
    vecs[16] = '{9'h092, 16'h0000, 3, 16'h000E};  // add R2,R2 doubles
    vecs[17] = '{9'h0D2, 16'h0000, 3, 16'h0000};  // sub R2,R2 clears, G=0
    vecs[18] = '{9'h160, 16'h0000, 1, 16'h0000};  // reserved 101
    vecs[19] = '{9'h1E0, 16'h0000, 1, 16'h0000};  // reserved 111
    vecs[20] = '{9'h024, 16'h0000, 1, 16'h1234};  // R4 untouched by NOPs
    vecs[21] = '{9'h093, 16'h0000, 3, 16'h0001};  // add R2,R3 -> G=1
    vecs[22] = '{9'h121, 16'h0000, 1, MVNZ ? 16'h0003 : 16'h0000};  // mvnz R4,R1, G!=0
    vecs[23] = '{9'h024, 16'h0000, 1, MVNZ ? 16'h0003 : 16'h1234};
    vecs[24] = '{9'h0DB, 16'h0000, 3, 16'h0000};  // sub R3,R3 -> G=0
    vecs[25] = '{9'h120, 16'h0000, 1, MVNZ ? 16'h1234 : 16'h0000};  // mvnz R4,R0, G==0
    vecs[26] = '{9'h024, 16'h0000, 1, MVNZ ? 16'h0003 : 16'h1234};

    reset = 1'b1;
    run   = 1'b0;
    din   = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("done_in_reset", 0, {15'd0, done}, 16'h0000);
    reset = 1'b0;

    // idle with run low: stays in T0
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("idle_done", i, {15'd0, done}, 16'h0000);
      chk("idle_bus", i, bus, 16'h0000);
    end

    for (int i = 0; i < 27; i++) begin
      exec(vecs[i], i);
    end

    // abort add R0,R1 by reset in T2
    tmp = '{9'h040, 16'h0005, 1, 16'h0005};
    exec(tmp, 100);
    @(negedge clock);
    din = 16'h0081;
    run = 1'b1;
    @(posedge clock);
    @(negedge clock);
    run = 1'b0;
    din = 16'h0000;
    #1;
    chk("abort_t1_bus", 101, bus, 16'h0005);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_done_in_reset", 102, {15'd0, done}, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_done_after", 103, {15'd0, done}, 16'h0000);
    chk("abort_bus_after", 104, bus, 16'h0000);
    chk("abort_g", 105, dut.r_g, 16'h0000);
    tmp = '{9'h000, 16'h0000, 1, 16'h0000};
    exec(tmp, 106);  // R0 cleared
    tmp = '{9'h009, 16'h0000, 1, 16'h0000};
    exec(tmp, 107);  // R1 cleared
    tmp = '{9'h024, 16'h0000, 1, 16'h0000};
    exec(tmp, 108);  // R4 cleared

    // back-to-back with run held high
    @(negedge clock);
    din = 16'h0040;
    run = 1'b1;
    @(posedge clock);
    @(negedge clock);
    din = 16'h00AA;
    #1;
    chk("b2b_t1_done", 200, {15'd0, done}, 16'h0001);
    chk("b2b_t1_bus", 200, bus, 16'h00AA);
    @(negedge clock);
    din = 16'h0000;
    #1;
    chk("b2b_t0_done", 201, {15'd0, done}, 16'h0000);
    @(negedge clock);
    run = 1'b0;
    #1;
    chk("b2b_next_done", 202, {15'd0, done}, 16'h0001);
    chk("b2b_next_bus", 202, bus, 16'h00AA);
    @(negedge clock);
    #1;
    chk("b2b_idle_done", 203, {15'd0, done}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
